// File: rtl/intc_pkg.sv
// intc_pkg: shared state encoding and register map for int_ctrl.
package intc_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_e;
  localparam logic [1:0] INTC_MASK = 2'd0;
  localparam logic [1:0] INTC_EDGE = 2'd1;
  localparam logic [1:0] INTC_PEND = 2'd2;
  localparam logic [1:0] INTC_STAT = 2'd3;
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-index-first priority encoder, reports any request plus winner index.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [4:0]   idx
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = 5'(i);
  end
  assign any = |req;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: prioritised interrupt controller with MASK/EDGE/PEND/STATUS registers and ack/eoi handshake.
// Define INTC_SYNC_EN to pass each irq bit through a 2-flop synchronizer before sampling.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  output logic            INTin,
  output logic [31:0]     INTnum,
  input  logic            int_ack,
  input  logic            eoi,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata
);
  intc_state_e     r_state, w_state_nx;
  logic [NSRC-1:0] r_mask, r_edge, r_pend, r_hist;
  logic [NSRC-1:0] w_irq_s, w_rise, w_w1c, w_ack_clr, w_pend_nx, w_elig;
  logic [4:0]      r_num, r_isr, w_win, w_num_nx, w_isr_nx;
  logic            w_any, w_unused;
`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] r_sync1, r_sync2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq;
      r_sync2 <= r_sync1;
    end
  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq;
`endif
  assign w_unused  = &{1'b0, cfg_wdata};
  assign w_rise    = w_irq_s & ~r_hist;
  assign w_w1c     = (cfg_we && cfg_addr == INTC_PEND) ? cfg_wdata[NSRC-1:0] & r_edge : '0;
  assign w_ack_clr = (r_state == REQ && int_ack) ? r_edge & (NSRC'(1) << r_num) : '0;
  // Edge bits: a new rise beats any clear in the same cycle; level bits track the input.
  assign w_pend_nx = (r_edge & (w_rise | (r_pend & ~(w_w1c | w_ack_clr)))) | (~r_edge & w_irq_s);
  assign w_elig    = r_pend & r_mask;
  intc_prio_enc #(.N(NSRC)) u_enc (
    .req(w_elig),
    .any(w_any),
    .idx(w_win)
  );
  always_comb begin
    w_state_nx = r_state;
    w_num_nx   = r_num;
    w_isr_nx   = r_isr;
    if (r_state == IDLE) begin
      if (w_any) begin
        w_state_nx = REQ;
        w_num_nx   = w_win;
      end
    end else if (r_state == REQ) begin
      if (int_ack) begin
        w_state_nx = SERVICE;
        w_isr_nx   = r_num;
      end else if (!w_any) w_state_nx = IDLE;
      else w_num_nx = w_win;
    end else if (eoi) w_state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_num   <= '0;
      r_isr   <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
      r_pend  <= '0;
      r_hist  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_num   <= w_num_nx;
      r_isr   <= w_isr_nx;
      r_pend  <= w_pend_nx;
      r_hist  <= w_irq_s;
      if (cfg_we && cfg_addr == INTC_MASK) r_mask <= cfg_wdata[NSRC-1:0];
      if (cfg_we && cfg_addr == INTC_EDGE) r_edge <= cfg_wdata[NSRC-1:0];
    end
  assign INTin     = r_state == REQ;
  assign INTnum    = 32'(r_num);
  assign cfg_rdata = cfg_addr == INTC_MASK ? 32'(r_mask) :
                     cfg_addr == INTC_EDGE ? 32'(r_edge) :
                     cfg_addr == INTC_PEND ? 32'(r_pend) :
                     {19'd0, r_isr, 6'd0, r_state};
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vector table, reset abort sequence and random traffic against a reference model.
module tb_int_ctrl;
  typedef struct {
    logic [7:0]  irq;
    logic        ack, eoi, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        e_in;
    logic [31:0] e_num;
    logic [7:0]  e_pend;
    logic [31:0] e_stat;
  } vec_t;
  logic        clk, rst, INTin, int_ack, eoi, cfg_we;
  logic [7:0]  irq;
  logic [31:0] INTnum, cfg_wdata, cfg_rdata;
  logic [1:0]  cfg_addr;
  int n_cmp, n_bad;
  vec_t tbl[$];
  int         m_st, m_num, m_isr;
  logic [7:0] m_mask, m_edge, m_pend, m_hist;
  int_ctrl #(.NSRC(8)) dut (
    .clk(clk), .rst(rst), .irq(irq), .INTin(INTin), .INTnum(INTnum),
    .int_ack(int_ack), .eoi(eoi), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );
  initial clk = 1'b0;
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic void add(int i_irq, int a, int e, int w, int ad, int wd,
                              int ein, int en, int ep, int es);
    tbl.push_back('{8'(i_irq), 1'(a), 1'(e), 1'(w), 2'(ad), 32'(wd),
                    1'(ein), 32'(en), 8'(ep), 32'(es)});
  endfunction
  function automatic void model_reset();
    m_st = 0; m_num = 0; m_isr = 0;
    m_mask = '0; m_edge = '0; m_pend = '0; m_hist = '0;
  endfunction
  function automatic logic [31:0] model_reg(int ad);
    case (ad)
      0: return 32'(m_mask);
      1: return 32'(m_edge);
      2: return 32'(m_pend);
      default: return 32'(m_isr * 256 + m_st);
    endcase
  endfunction
  // One clock edge of the controller, worked out from the register/handshake rules.
  function automatic void model_step(logic [7:0] ir, logic a, logic e, logic w, logic [1:0] ad, logic [31:0] wd);
    int win, ost, onum;
    bit rise, clr;
    win = -1;
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && m_mask[i]) begin
        win = i;
        break;
      end
    ost = m_st;
    onum = m_num;
    if (ost == 0 && win >= 0) begin
      m_st = 1; m_num = win;
    end else if (ost == 1) begin
      if (a) begin m_st = 2; m_isr = onum; end
      else if (win < 0) m_st = 0;
      else m_num = win;
    end else if (ost == 2 && e) m_st = 0;
    for (int i = 0; i < 8; i++)
      if (m_edge[i]) begin
        rise = ir[i] && !m_hist[i];
        clr = (w && ad == 2 && wd[i]) || (ost == 1 && a && onum == i);
        m_pend[i] = rise || (m_pend[i] && !clr);
      end else m_pend[i] = ir[i];
    m_hist = ir;
    if (w && ad == 0) m_mask = wd[7:0];
    if (w && ad == 1) m_edge = wd[7:0];
  endfunction
  task automatic tick(input logic [7:0] i_irq, input logic a, input logic e, input logic w,
                      input logic [1:0] ad, input logic [31:0] wd);
    @(negedge clk);
    irq = i_irq; int_ack = a; eoi = e; cfg_we = w; cfg_addr = ad; cfg_wdata = wd;
    @(posedge clk);
    model_step(i_irq, a, e, w, ad, wd);
    #1;
    cfg_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    chk("m_intin", 32'(INTin), 32'(m_st == 1));
    chk("m_intnum", INTnum, 32'(m_num));
    for (int r = 0; r < 4; r++) begin
      cfg_addr = 2'(r);
      #1;
      chk($sformatf("m_reg%0d", r), cfg_rdata, model_reg(r));
    end
  endtask
  initial begin
    logic [7:0] ir;
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; irq = '0; int_ack = 0; eoi = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    add(0,0,0,1,0,'hFF, 0,0,0,0);
    add(0,0,0,1,1,'hFF, 0,0,0,0);
    add('h08,0,0,0,0,0, 0,0,'h08,0);
    add(0,0,0,0,0,0, 1,3,'h08,'h001);
    add(0,1,0,0,0,0, 0,3,0,'h302);
    add(0,0,0,0,0,0, 0,3,0,'h302);
    add(0,0,1,0,0,0, 0,3,0,'h300);
    add('h24,0,0,0,0,0, 0,3,'h24,'h300);
    add(0,0,0,0,0,0, 1,2,'h24,'h301);
    add(0,1,0,0,0,0, 0,2,'h20,'h202);
    add(0,0,1,0,0,0, 0,2,'h20,'h200);
    add(0,0,0,0,0,0, 1,5,'h20,'h201);
    add(0,1,0,0,0,0, 0,5,0,'h502);
    add(0,0,1,0,0,0, 0,5,0,'h500);
    add('h40,0,0,0,0,0, 0,5,'h40,'h500);
    add(0,0,0,0,0,0, 1,6,'h40,'h501);
    add('h02,0,0,0,0,0, 1,6,'h42,'h501);
    add(0,0,0,0,0,0, 1,1,'h42,'h501);
    add(0,1,0,0,0,0, 0,1,'h40,'h102);
    add(0,0,1,0,0,0, 0,1,'h40,'h100);
    add(0,0,0,0,0,0, 1,6,'h40,'h101);
    add(0,1,0,0,0,0, 0,6,0,'h602);
    add(0,0,1,0,0,0, 0,6,0,'h600);
    add(0,0,0,1,1,'hEF, 0,6,0,'h600);
    add('h10,0,0,0,0,0, 0,6,'h10,'h600);
    add('h10,0,0,0,0,0, 1,4,'h10,'h601);
    add(0,0,0,0,0,0, 1,4,0,'h601);
    add(0,0,0,0,0,0, 0,4,0,'h600);
    add('h10,0,0,0,0,0, 0,4,'h10,'h600);
    add('h10,0,0,0,0,0, 1,4,'h10,'h601);
    add('h10,0,0,1,0,'hEF, 1,4,'h10,'h601);
    add('h10,0,0,0,0,0, 0,4,'h10,'h600);
    add(0,0,0,1,0,'hFF, 0,4,0,'h600);
    add('h01,0,0,1,2,'h01, 0,4,'h01,'h600);
    add('h01,0,0,0,0,0, 1,0,'h01,'h601);
    add('h01,0,0,1,2,'h01, 1,0,0,'h601);
    add(0,0,0,0,0,0, 0,0,0,'h600);
    add(0,1,1,0,0,0, 0,0,0,'h600);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_intin", 32'(INTin), 32'd0);
    chk("rst_intnum", INTnum, 32'd0);
    for (int r = 0; r < 4; r++) begin
      cfg_addr = 2'(r);
      #1;
      chk($sformatf("rst_reg%0d", r), cfg_rdata, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      tick(tbl[i].irq, tbl[i].ack, tbl[i].eoi, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      chk($sformatf("v%0d_intin", i), 32'(INTin), 32'(tbl[i].e_in));
      chk($sformatf("v%0d_intnum", i), INTnum, tbl[i].e_num);
      cfg_addr = 2'd2;
      #1;
      chk($sformatf("v%0d_pend", i), cfg_rdata, 32'(tbl[i].e_pend));
      cfg_addr = 2'd3;
      #1;
      chk($sformatf("v%0d_stat", i), cfg_rdata, tbl[i].e_stat);
    end
    tick(8'h01, 0, 0, 0, 2'd0, 0);
    tick(8'h00, 0, 0, 0, 2'd0, 0);
    tick(8'h00, 1, 0, 0, 2'd0, 0);
    cfg_addr = 2'd3;
    #1;
    chk("svc_stat", cfg_rdata, 32'h002);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_intin", 32'(INTin), 32'd0);
    chk("abort_intnum", INTnum, 32'd0);
    cfg_addr = 2'd0;
    #1;
    chk("abort_mask", cfg_rdata, 32'd0);
    cfg_addr = 2'd3;
    #1;
    chk("abort_stat", cfg_rdata, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(8'h00, 0, 0, 1, 2'd0, $urandom | 32'h0F);
    tick(8'h00, 0, 0, 1, 2'd1, $urandom);
    ir = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) ir = 8'($urandom);
      tick(ir, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 9) == 0), 2'($urandom), $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Prioritised interrupt controller that drives the CPU's `INTin`/`INTnum` interrupt port. It collects up to `NSRC` peripheral requests, applies per-source enable masks and edge/level selection, and presents the highest-priority pending source to the CPU. It then sequences the acknowledge and end-of-interrupt handshake. A small register port, decoded from the memory bus by the system glue, configures the block.

## Interface
- `NSRC`, 8, number of interrupt sources (1..32); index 0 is highest priority
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `irq`  in  NSRC  raw interrupt requests, active-high
- `INTin`  out  1  interrupt request to the CPU
- `INTnum`  out  32  number of the presented source, zero-extended
- `int_ack`  in  1  one-cycle pulse: the CPU accepted the request and sampled `INTnum`
- `eoi`  in  1  one-cycle pulse: the CPU finished servicing
- `cfg_we`  in  1  register write strobe
- `cfg_addr`  in  2  register select
- `cfg_wdata`  in  32  write data
- `cfg_rdata`  out  32  read data, combinational from `cfg_addr`

## Operation
- **Registers**
  - 0 MASK: 1 = source enabled.
  - 1 EDGE: 1 = edge-triggered, 0 = level.
  - 2 PEND: read gives pending; write-1-to-clear applies to edge bits only.
  - 3 STATUS: [1:0] = state, [12:8] = in-service id.
  - Unused high bits read 0.
- **Pending**
  - Edge source: the bit sets on a 0→1 transition of the sampled input. It clears on W1C, or on `int_ack` while that source is presented.
  - Set wins over a simultaneous clear.
  - Level source: the pending bit equals the sampled input. It is not cleared by `int_ack`.
- **Selection:** `eligible = pend & MASK`. The winner is the lowest set index.
- **FSM states:** IDLE=0, REQ=1, SERVICE=2.
  - IDLE → REQ when `eligible != 0`. `INTnum` loads the winner.
  - REQ:
    - `INTnum` re-evaluates every cycle, so a higher-priority arrival replaces the presented number.
    - `int_ack` → SERVICE. The in-service id latches the current `INTnum`.
    - If `eligible` becomes 0 (source masked or level dropped) → IDLE.
  - SERVICE: `eoi` → IDLE. New pending sources accumulate, and no further request is issued until `eoi`.
- `INTin` is 1 only in REQ.
- `int_ack` outside REQ is ignored. `eoi` outside SERVICE is ignored.
- **Reset values:** state IDLE, `INTin` 0, `INTnum` 0, MASK 0, EDGE 0, pending 0, in-service id 0. Input history resets to 0.
- Asserting `rst` mid-handshake aborts it; the CPU sees `INTin` fall asynchronously.

## Timing
- Without sync: an `irq` edge sampled at clock edge k sets pending at k. The FSM enters REQ at k+1, so `INTin` is high after k+1 (latency 2 edges).
- `int_ack` at edge m: `INTin` is low after m, and edge pending is cleared at m.
- After `eoi` at edge e, the FSM is IDLE after e. An already-pending source re-raises `INTin` after e+1.
- Register writes take effect at the write edge. A MASK write affects selection from the next cycle.

## Configuration
- `INTC_SYNC_EN`
  - Defined: each `irq` bit passes through a 2-flop synchronizer before edge detection and level sampling. This adds 2 cycles of latency (`INTin` after k+3).
  - Undefined: `irq` is sampled directly, and sources must be synchronous to `clk`.

## Structure
- Shared package `intc_pkg`:
  - state encoding constants (IDLE/REQ/SERVICE);
  - register address constants (`INTC_MASK`, `INTC_EDGE`, `INTC_PEND`, `INTC_STAT`).
- Sub-module `intc_prio_enc`: combinational lowest-index-first priority encoder. It outputs `any` plus a 5-bit index.

## Test plan
- **Basic edge request:** MASK=0xFF, EDGE=0xFF; pulse `irq[3]`. Expect `INTin`=1 and `INTnum`=3 two cycles later. `int_ack` drops `INTin` and clears PEND bit 3. `eoi` gives STATUS state 0.
- **Priority:** `irq[5]` and `irq[2]` rise together. Expect `INTnum`=2. After ack/eoi, expect `INTin` re-raised with `INTnum`=5.
- **Preemption in REQ:** `irq[6]` is presented; `irq[1]` rises before ack. Expect `INTnum` to switch to 1. Ack then latches in-service id 1.
- **Masking and level drop:** level source 4 in REQ. Either deassert `irq[4]` or clear MASK bit 4. Expect `INTin`=0 the next cycle and state IDLE.
- **W1C race:** write PEND=0x01 in the same cycle `irq[0]` rises. Expect PEND bit 0 to remain 1.
- **Reset mid-SERVICE:** assert `rst` low. Expect `INTin`=0, `INTnum`=0, MASK=0, and STATUS=0 immediately.
